// File: rtl/tempo_pkg.sv
// Shared types and constants for the tempo window controller.
// Holds the FSM state encoding, the BPM table and the magnitude helper.
package tempo_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_WARMUP,
    S_ACCUM,
    S_COMPARE,
    S_PRESENT
  } state_e;

  localparam int NUM_TEMPI = 6;

  localparam logic [NUM_TEMPI-1:0][7:0] BPM_TAB = {
    8'd240, 8'd210, 8'd180, 8'd120, 8'd90, 8'd60
  };

  function automatic logic [7:0] bpm_of(input logic [2:0] idx);
    logic [7:0] r;
    r = 8'd0;
    for (int i = 0; i < NUM_TEMPI; i++)
      if (idx == 3'(i)) r = BPM_TAB[i];
    return r;
  endfunction

  // two's-complement magnitude; -128 lands on 128, which still fits 8 bits
  function automatic logic [7:0] mag8(input logic [7:0] v);
    return v[7] ? (~v + 8'd1) : v;
  endfunction

endpackage

// File: rtl/tempo_window_ctrl_accum.sv
// Saturating magnitude accumulator for one comb channel.
// Module tempo_accum: clear wins over enable.
module tempo_accum
  import tempo_pkg::*;
#(
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [7:0]       din,
  output logic [ACC_W-1:0] acc
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W:0]   sum;

  always_comb begin
    sum   = {1'b0, acc_q} + {{(ACC_W-7){1'b0}}, mag8(din)};
    acc_d = acc_q;
    if (clr)
      acc_d = '0;
    else if (en)
      acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/tempo_window_ctrl.sv
// Tempo window controller: flush, warm-up, accumulate, pick, present.
// Define TEMPO_CONTINUOUS_EN for back-to-back windows after each ack.
module tempo_window_ctrl
  import tempo_pkg::*;
#(
  parameter int DECIM        = 4,
  parameter int FLUSH_CYCLES = 16,
  parameter int WARMUP       = 256,
  parameter int WINDOW       = 1024,
  parameter int CAPTURE_DLY  = 2,
  parameter int ACC_W        = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              audio_ready,
  input  logic signed [7:0] comb60,
  input  logic signed [7:0] comb90,
  input  logic signed [7:0] comb120,
  input  logic signed [7:0] comb180,
  input  logic signed [7:0] comb210,
  input  logic signed [7:0] comb240,
  output logic              apu_reset,
  output logic              apu_ready,
  output logic [2:0]        tempo_idx,
  output logic [7:0]        tempo_bpm,
  output logic              tempo_valid,
  input  logic              tempo_ack,
  output logic              busy
);

  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;

  state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  sc_q, sc_d;
  logic [2:0]  bidx_q, bidx_d;
  logic [ACC_W-1:0] best_q, best_d;
  logic [DW-1:0] dec_q, dec_d;
  logic [CAPTURE_DLY-1:0] cap_q, cap_d;
  logic apu_ready_q, apu_ready_d;
  logic valid_q, valid_d;
  logic busy_q, busy_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] bpm_q, bpm_d;

  logic clr_acc;
  logic cap_fire;
  logic dec_active;
  logic [ACC_W-1:0] acc_sel;
  logic [7:0] comb_arr [NUM_TEMPI];
  logic [ACC_W-1:0] acc_arr [NUM_TEMPI];

  assign comb_arr[0] = comb60;
  assign comb_arr[1] = comb90;
  assign comb_arr[2] = comb120;
  assign comb_arr[3] = comb180;
  assign comb_arr[4] = comb210;
  assign comb_arr[5] = comb240;

  assign dec_active = state_q inside {S_WARMUP, S_ACCUM, S_COMPARE, S_PRESENT};
  assign cap_fire   = cap_q[CAPTURE_DLY-1] && (state_q == S_ACCUM);

  for (genvar g = 0; g < NUM_TEMPI; g++) begin : g_acc
    tempo_accum #(.ACC_W(ACC_W)) u_acc (
      .clk   (clk),
      .reset (reset),
      .clr   (clr_acc),
      .en    (cap_fire),
      .din   (comb_arr[g]),
      .acc   (acc_arr[g])
    );
  end

  always_comb begin
    acc_sel = '0;
    for (int i = 0; i < NUM_TEMPI; i++)
      if (sc_q == 3'(i)) acc_sel = acc_arr[i];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sc_d    = sc_q;
    best_d  = best_q;
    bidx_d  = bidx_q;
    clr_acc = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        clr_acc = 1'b1;
        if (start) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (cnt_q == 16'(FLUSH_CYCLES-1)) begin
          cnt_d   = '0;
          state_d = S_WARMUP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WARMUP: begin
        if (apu_ready_q) begin
          if (cnt_q == 16'(WARMUP-1)) begin
            cnt_d   = '0;
            state_d = S_ACCUM;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_ACCUM: begin
        if (cap_fire) begin
          if (cnt_q == 16'(WINDOW-1)) begin
            cnt_d   = '0;
            sc_d    = '0;
            state_d = S_COMPARE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_COMPARE: begin
        sc_d = sc_q + 3'd1;
        // strict compare keeps the lower index on ties
        if (sc_q == 3'd0 || acc_sel > best_q) begin
          best_d = acc_sel;
          bidx_d = sc_q;
        end
        if (sc_q == 3'(NUM_TEMPI-1)) state_d = S_PRESENT;
      end
      S_PRESENT: begin
        if (tempo_ack) begin
`ifdef TEMPO_CONTINUOUS_EN
          clr_acc = 1'b1;
          cnt_d   = '0;
          state_d = S_ACCUM;
`else
          state_d = S_IDLE;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dec_d       = dec_q;
    apu_ready_d = 1'b0;
    if (!dec_active) begin
      dec_d = '0;
    end else if (audio_ready) begin
      if (dec_q == DW'(DECIM-1)) begin
        dec_d       = '0;
        apu_ready_d = (state_d != S_IDLE);
      end else begin
        dec_d = dec_q + DW'(1);
      end
    end
    cap_d[0] = apu_ready_q && (state_q == S_ACCUM);
    for (int i = 1; i < CAPTURE_DLY; i++)
      cap_d[i] = cap_q[i-1];
    valid_d = valid_q;
    idx_d   = idx_q;
    bpm_d   = bpm_q;
    if (state_q == S_COMPARE && sc_q == 3'(NUM_TEMPI-1)) begin
      valid_d = 1'b1;
      idx_d   = bidx_d;
      bpm_d   = bpm_of(bidx_d);
    end
    if (state_q == S_PRESENT && tempo_ack) valid_d = 1'b0;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sc_q        <= '0;
      best_q      <= '0;
      bidx_q      <= '0;
      dec_q       <= '0;
      cap_q       <= '0;
      apu_ready_q <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      idx_q       <= '0;
      bpm_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sc_q        <= sc_d;
      best_q      <= best_d;
      bidx_q      <= bidx_d;
      dec_q       <= dec_d;
      cap_q       <= cap_d;
      apu_ready_q <= apu_ready_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      idx_q       <= idx_d;
      bpm_q       <= bpm_d;
    end
  end

  assign apu_reset   = reset | (state_q == S_FLUSH);
  assign apu_ready   = apu_ready_q;
  assign tempo_valid = valid_q;
  assign tempo_idx   = idx_q;
  assign tempo_bpm   = bpm_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_tempo_window_ctrl.sv
// Directed bench for tempo_window_ctrl with small window parameters.
// A second instance with ACC_W=9 exercises accumulator saturation.
module tb_tempo_window_ctrl;

  logic clk;
  logic reset;
  logic start;
  logic audio_ready;
  logic [7:0] c60, c90, c120, c180, c210, c240;
  logic tempo_ack;

  logic apu_reset, apu_ready, tempo_valid, busy;
  logic [2:0] tempo_idx;
  logic [7:0] tempo_bpm;

  logic s_apu_reset, s_apu_ready, s_valid, s_busy;
  logic [2:0] s_idx;
  logic [7:0] s_bpm;

  int checks = 0;
  int errors = 0;

  tempo_window_ctrl #(
    .DECIM(2), .FLUSH_CYCLES(4), .WARMUP(4),
    .WINDOW(8), .CAPTURE_DLY(2), .ACC_W(20)
  ) u_dut (
    .clk(clk), .reset(reset), .start(start),
    .audio_ready(audio_ready),
    .comb60(c60), .comb90(c90), .comb120(c120),
    .comb180(c180), .comb210(c210), .comb240(c240),
    .apu_reset(apu_reset), .apu_ready(apu_ready),
    .tempo_idx(tempo_idx), .tempo_bpm(tempo_bpm),
    .tempo_valid(tempo_valid), .tempo_ack(tempo_ack),
    .busy(busy)
  );

  tempo_window_ctrl #(
    .DECIM(2), .FLUSH_CYCLES(4), .WARMUP(4),
    .WINDOW(8), .CAPTURE_DLY(2), .ACC_W(9)
  ) u_sat (
    .clk(clk), .reset(reset), .start(start),
    .audio_ready(audio_ready),
    .comb60(c60), .comb90(c90), .comb120(c120),
    .comb180(c180), .comb210(c210), .comb240(c240),
    .apu_reset(s_apu_reset), .apu_ready(s_apu_ready),
    .tempo_idx(s_idx), .tempo_bpm(s_bpm),
    .tempo_valid(s_valid), .tempo_ack(tempo_ack),
    .busy(s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    audio_ready = 1'b0;
    forever begin
      repeat (4) @(negedge clk);
      audio_ready = 1'b1;
      @(negedge clk);
      audio_ready = 1'b0;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_comb(input logic [7:0] a, b, c, d, e, f);
    c60 = a; c90 = b; c120 = c; c180 = d; c210 = e; c240 = f;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_start(input string tag);
    int n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_rise"}, busy, 1);
    chk({tag, "_apu_rst_rise"}, apu_reset, 1);
    n = 0;
    while (apu_reset && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_flush_len"}, n, 4);
  endtask

  task automatic wait_valid(input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      if (tempo_valid) got = 1'b1;
      else @(negedge clk);
    end
    chk({tag, "_valid_seen"}, got, 1);
  endtask

  task automatic run_case(input string tag, input int exp_idx,
                          input int exp_bpm);
    pulse_reset();
    do_start(tag);
    wait_valid(tag);
    chk({tag, "_idx"}, tempo_idx, exp_idx);
    chk({tag, "_bpm"}, tempo_bpm, exp_bpm);
    repeat (3) @(negedge clk);
    chk({tag, "_valid_hold"}, tempo_valid, 1);
    chk({tag, "_idx_hold"}, tempo_idx, exp_idx);
    tempo_ack = 1'b1;
    @(negedge clk);
    tempo_ack = 1'b0;
    chk({tag, "_valid_clr"}, tempo_valid, 0);
`ifdef TEMPO_CONTINUOUS_EN
    chk({tag, "_busy_after"}, busy, 1);
`else
    chk({tag, "_busy_after"}, busy, 0);
`endif
  endtask

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    tempo_ack = 1'b0;
    set_comb(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    repeat (3) @(negedge clk);
    chk("rst_apu_reset_hi", apu_reset, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_apu_reset_lo", apu_reset, 0);
    chk("rst_apu_ready", apu_ready, 0);
    chk("rst_valid", tempo_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_idx", tempo_idx, 0);
    chk("rst_bpm", tempo_bpm, 0);

    tempo_ack = 1'b1;
    repeat (2) @(negedge clk);
    tempo_ack = 1'b0;
    chk("idle_ack_busy", busy, 0);
    chk("idle_ack_valid", tempo_valid, 0);

    set_comb(8'd2, 8'd2, 8'd10, 8'd2, 8'd2, 8'd2);
    run_case("basic", 2, 120);

    set_comb(8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd5);
    run_case("tie", 0, 60);

    set_comb(8'd0, 8'h80, 8'd0, 8'd127, 8'd0, 8'd0);
    run_case("mag", 1, 90);

    // 63*8=504 stays below 511; 100*8 only wins if it saturates
    set_comb(8'd63, 8'd0, 8'd0, 8'd0, 8'd100, 8'd100);
    run_case("sat", 4, 210);
    chk("sat_w9_idx", s_idx, 4);
    chk("sat_w9_bpm", s_bpm, 210);

    set_comb(8'd0, 8'd0, 8'd0, 8'd100, 8'd0, 8'd0);
    pulse_reset();
    do_start("mid");
    n = 0;
    for (int i = 0; i < 2000 && n < 6; i++) begin
      @(negedge clk);
      if (apu_ready) n++;
    end
    chk("mid_pulses", n, 6);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_busy", busy, 0);
    chk("mid_apu_reset", apu_reset, 0);
    chk("mid_valid", tempo_valid, 0);
    set_comb(8'd2, 8'd2, 8'd10, 8'd2, 8'd2, 8'd2);
    do_start("mid_restart");
    wait_valid("mid_restart");
    chk("mid_restart_idx", tempo_idx, 2);

`ifdef TEMPO_CONTINUOUS_EN
    begin
      int np, nr;
      bit got;
      tempo_ack = 1'b1;
      @(negedge clk);
      tempo_ack = 1'b0;
      np = 0;
      nr = 0;
      got = 1'b0;
      for (int i = 0; i < 2000 && !got; i++) begin
        if (tempo_valid) got = 1'b1;
        else begin
          if (apu_ready) np++;
          if (apu_reset) nr++;
          @(negedge clk);
        end
      end
      chk("cont_valid_seen", got, 1);
      chk("cont_pulses", np, 8);
      chk("cont_no_apu_reset", nr, 0);
      chk("cont_idx", tempo_idx, 2);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tempo_window_ctrl.md
# tempo_window_ctrl

Sequencing controller for the audio processing unit's onset/comb datapath. It holds the processing unit in reset to flush its filters, then paces it with decimated `ready` strobes through a warm-up period. Over a fixed analysis window it accumulates the magnitude of each of the six comb-filter outputs, selects the strongest tempo, and presents the result to the display/beat logic on a valid/ack handshake.

## Interface
Parameters:
- `DECIM`, 4: audio sample strobes per `apu_ready` pulse (≥1).
- `FLUSH_CYCLES`, 16: clock cycles `apu_reset` is held after `start`.
- `WARMUP`, 256: `apu_ready` pulses ignored before accumulation.
- `WINDOW`, 1024: captures accumulated per decision.
- `CAPTURE_DLY`, 2: cycles from `apu_ready` to comb sampling.
- `ACC_W`, 20: accumulator width; accumulators saturate.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: begin analysis; sampled only in IDLE.
- `audio_ready`, in, 1: one-cycle strobe per audio sample.
- `comb60`/`comb90`/`comb120`/`comb180`/`comb210`/`comb240`, in, 8 each, signed: comb outputs.
- `apu_reset`, out, 1: reset to the processing unit.
- `apu_ready`, out, 1: one-cycle pacing strobe to the processing unit.
- `tempo_idx`, out, 3: winning channel, 0 = 60 through 5 = 240.
- `tempo_bpm`, out, 8: BPM for `tempo_idx`.
- `tempo_valid`, out, 1: result held valid.
- `tempo_ack`, in, 1: consumer accepts the result.
- `busy`, out, 1: high in every state except IDLE.

## Operation
- States: IDLE → FLUSH → WARMUP → ACCUM → COMPARE → PRESENT.
- IDLE:
  - `start` moves to FLUSH.
  - Accumulators and counters are cleared.
- FLUSH:
  - `apu_reset` is high for exactly `FLUSH_CYCLES` cycles.
  - `audio_ready` is ignored.
  - The decimation counter is cleared on exit.
- Decimation:
  - Active in WARMUP, ACCUM, COMPARE and PRESENT.
  - Counts `audio_ready` strobes. On the `DECIM`-th strobe the counter wraps to 0 and `apu_ready` pulses.
- WARMUP: counts `apu_ready` pulses and moves to ACCUM after `WARMUP` pulses.
- ACCUM:
  - `CAPTURE_DLY` cycles after each `apu_ready`, samples all six comb inputs.
  - Adds the magnitude of each input to its accumulator. Magnitude is unsigned 8-bit, and −128 maps to 128.
  - Each accumulator saturates at 2^ACC_W−1.
  - After `WINDOW` captures, moves to COMPARE.
  - Captures whose delay expires outside ACCUM are discarded.
- COMPARE:
  - Scans indices 0..5, one per cycle (6 cycles).
  - Strict greater-than replaces the best, so ties keep the lower index.
- PRESENT:
  - `tempo_valid` is high and `tempo_idx`/`tempo_bpm` are stable.
  - `tempo_ack` high clears `tempo_valid` next cycle and goes to IDLE.
- `start` is ignored outside IDLE.
- `reset` mid-operation:
  - Returns to IDLE on the next edge, and all state is cleared.
  - `apu_reset` = `reset` OR (state == FLUSH).

## Timing
- Reset values:
  - `apu_reset` 1 while `reset` is high, 0 after.
  - `apu_ready`, `tempo_valid` and `busy` are 0.
  - `tempo_idx` 0, `tempo_bpm` 0.
- `busy` rises the cycle after `start` is accepted.
- `apu_reset` rises the same cycle as `busy`.
- `apu_ready` is asserted the cycle after the qualifying `audio_ready`.
- The first `apu_ready` needs `DECIM` strobes after FLUSH exit.
- `tempo_valid` rises exactly 7 cycles after the final capture: 6 COMPARE cycles plus 1 register.
- Ack handshake:
  - An ack in the same cycle `tempo_valid` first rises is accepted.
  - An ack while not in PRESENT is ignored.
- Outputs are registered, with no combinational input-to-output paths except `apu_reset` from `reset`.

## Configuration
- Macro `TEMPO_CONTINUOUS_EN`.
- Defined:
  - After ack, clears the accumulators and goes straight to ACCUM, skipping FLUSH and WARMUP.
  - Pacing never stops.
  - Only `reset` returns to IDLE.
  - `busy` stays high.
- Undefined: single-shot; ack returns to IDLE and pacing stops.

## Structure
- Shared package `tempo_pkg` holds:
  - State enum.
  - `NUM_TEMPI = 6`.
  - BPM constant table: 60, 90, 120, 180, 210, 240.
  - Magnitude function.
- Sub-module `tempo_accum`: one saturating magnitude accumulator with clear and enable, instantiated six times.
- The FSM, decimator, capture delay line and comparator stay in the top module.

## Test plan
Bench parameters: `DECIM`=2, `FLUSH_CYCLES`=4, `WARMUP`=4, `WINDOW`=8, `audio_ready` every 5 cycles.

- Reset held 3 cycles:
  - During reset: `apu_reset`=1.
  - After reset: `apu_reset`=0, all other outputs 0, `busy`=0.
- `start`; `comb120`=10, others 2:
  - `apu_reset` high exactly 4 cycles.
  - `tempo_idx`=2, `tempo_bpm`=120, `tempo_valid` held until `tempo_ack`, then `busy`=0.
- Tie: `comb60`=`comb240`=5, others 0 → `tempo_idx`=0.
- Magnitude: `comb90`=−128 (sum 1024) vs `comb180`=127 (sum 1016) → `tempo_idx`=1.
- Saturation with `ACC_W`=9: `comb210`=`comb240`=100 both saturate at 511 → `tempo_idx`=4.
- `reset` mid-ACCUM, then `start`:
  - After `reset`: IDLE, `busy`=0.
  - After `start`: full FLUSH repeated.
- With `TEMPO_CONTINUOUS_EN`: after ack, next `tempo_valid` arrives after 8 captures with no `apu_reset` pulse.
